// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: immediate format select, opcode constants and the
// ID/EX control bundle used by the decode stage and the immediate extender.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic trap;
  } id_ex_ctrl_t;

  localparam int CTRL_W = $bits(id_ex_ctrl_t);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/rv32_opcode_decoder.sv
// Pure combinational RV32I opcode decoder: immediate format, source-register
// usage, ID/EX control bits and trap/illegal classification.
module rv32_opcode_decoder
  import rv32_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [2:0]        imm_fmt,
  output logic              uses_rs1,
  output logic              uses_rs2,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              is_trap
);

  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic        rd_written;
  imm_fmt_t    fmt;
  id_ex_ctrl_t c;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign imm_fmt = fmt;
  assign ctrl    = c;

  always_comb begin
    fmt        = FMT_NONE;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    rd_written = 1'b0;
    illegal    = 1'b0;
    c          = '0;
    case (opcode)
      OPC_LOAD: begin
        fmt        = FMT_I;
        uses_rs1   = 1'b1;
        rd_written = 1'b1;
        c.mem_read = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt        = FMT_I;
        uses_rs1   = 1'b1;
        rd_written = 1'b1;
      end
      OPC_JALR: begin
        fmt        = FMT_I;
        uses_rs1   = 1'b1;
        rd_written = 1'b1;
        c.jump     = 1'b1;
      end
      OPC_SYSTEM, OPC_MISC_MEM: begin
        fmt      = FMT_I;
        uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        fmt         = FMT_S;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        c.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        fmt      = FMT_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        c.branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt        = FMT_U;
        rd_written = 1'b1;
      end
      OPC_JAL: begin
        fmt        = FMT_J;
        rd_written = 1'b1;
        c.jump     = 1'b1;
      end
      OPC_OP: begin
        fmt        = FMT_NONE;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        rd_written = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    is_trap     = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    c.reg_write = rd_written && (rd_idx != 5'd0);

    // Trapping instructions travel down the pipe with no architectural side effects.
    if (is_trap || illegal) begin
      c.reg_write = 1'b0;
      c.mem_read  = 1'b0;
      c.mem_write = 1'b0;
      c.trap      = 1'b1;
    end
  end

endmodule

// File: rtl/decode_hazard_controller.sv
// ID-stage sequencer: owns the ID/EX control register, load-use interlock,
// flush handling, RUN/HALT trap FSM and a saturating stall-cycle counter.
module decode_hazard_controller
  import rv32_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instr,
  input  logic               flush_in,
  input  logic               resume_in,
  output logic [2:0]         imm_format,
  output logic               stall_out,
  output logic               halted,
  output logic               id_ex_valid,
  output logic [4:0]         id_ex_rs1,
  output logic [4:0]         id_ex_rs2,
  output logic [4:0]         id_ex_rd,
  output logic [2:0]         id_ex_imm_format,
  output logic               id_ex_reg_write,
  output logic               id_ex_mem_read,
  output logic               id_ex_mem_write,
  output logic               id_ex_branch,
  output logic               id_ex_jump,
  output logic               id_ex_trap,
  output logic [COUNT_W-1:0] stall_count
);

  state_t            state, state_next;
  logic [2:0]        dec_fmt;
  logic              dec_uses_rs1, dec_uses_rs2;
  logic [CTRL_W-1:0] dec_ctrl_bits;
  id_ex_ctrl_t       dec_ctrl, ctrl_q;
  logic              dec_illegal, dec_is_trap;
  logic [4:0]        rs1_field, rs2_field, rd_field;
  logic              rs1_hit, rs2_hit, hazard, issue_live;

  rv32_opcode_decoder u_decoder (
    .instr    (if_id_instr),
    .imm_fmt  (dec_fmt),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .ctrl     (dec_ctrl_bits),
    .illegal  (dec_illegal),
    .is_trap  (dec_is_trap)
  );

  assign dec_ctrl   = id_ex_ctrl_t'(dec_ctrl_bits);
  assign imm_format = dec_fmt;
  assign rs1_field  = if_id_instr[19:15];
  assign rs2_field  = if_id_instr[24:20];
  assign rd_field   = if_id_instr[11:7];
  assign halted     = (state == ST_HALT);

  // A load writing x0 never produces a value, so it cannot cause an interlock.
  assign rs1_hit = dec_uses_rs1 && (rs1_field == id_ex_rd);
  assign rs2_hit = dec_uses_rs2 && (rs2_field == id_ex_rd);
  assign hazard  = if_id_valid && id_ex_valid && id_ex_mem_read &&
                   (id_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    issue_live = 1'b0;
    if (flush_in) begin
      stall_out = 1'b0;
    end else if (state == ST_HALT) begin
      stall_out = 1'b1;
      if (resume_in) begin
        state_next = ST_RUN;
      end
    end else if (hazard) begin
      stall_out = 1'b1;
    end else if (if_id_valid) begin
      issue_live = 1'b1;
      if (dec_is_trap || dec_illegal) begin
        state_next = ST_HALT;
      end
    end
  end

  // Every non-issue cycle loads a fully cleared bubble so no stale fields linger.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RESET_HALTED ? ST_HALT : ST_RUN;
      id_ex_valid      <= 1'b0;
      id_ex_rs1        <= 5'd0;
      id_ex_rs2        <= 5'd0;
      id_ex_rd         <= 5'd0;
      id_ex_imm_format <= 3'd0;
      ctrl_q           <= '0;
      stall_count      <= '0;
    end else begin
      state <= state_next;
      if (issue_live) begin
        id_ex_valid      <= 1'b1;
        id_ex_rs1        <= rs1_field;
        id_ex_rs2        <= rs2_field;
        id_ex_rd         <= rd_field;
        id_ex_imm_format <= dec_fmt;
        ctrl_q           <= dec_ctrl;
      end else begin
        id_ex_valid      <= 1'b0;
        id_ex_rs1        <= 5'd0;
        id_ex_rs2        <= 5'd0;
        id_ex_rd         <= 5'd0;
        id_ex_imm_format <= 3'd0;
        ctrl_q           <= '0;
      end
      if (stall_out && (stall_count != '1)) begin
        stall_count <= stall_count + COUNT_W'(1);
      end
    end
  end

  assign id_ex_reg_write = ctrl_q.reg_write;
  assign id_ex_mem_read  = ctrl_q.mem_read;
  assign id_ex_mem_write = ctrl_q.mem_write;
  assign id_ex_branch    = ctrl_q.branch;
  assign id_ex_jump      = ctrl_q.jump;
  assign id_ex_trap      = ctrl_q.trap;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Self-checking bench for decode_hazard_controller: vector table with a
// scoreboard for registered results, plus a saturation/debug-boot sequence.
module tb_decode_hazard_controller;

  localparam logic [31:0] LW    = 32'h0000A283;
  localparam logic [31:0] ADD   = 32'h00228333;
  localparam logic [31:0] LW0   = 32'h00002003;
  localparam logic [31:0] ADD0  = 32'h00200333;
  localparam logic [31:0] SW    = 32'h0050A023;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] LUI   = 32'h123452B7;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_id_valid, flush_in, resume_in;
  logic [31:0] if_id_instr;
  logic [2:0]  imm_format, id_ex_imm_format;
  logic        stall_out, halted, id_ex_valid;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_branch, id_ex_jump, id_ex_trap;
  logic [31:0] stall_count;

  logic        reset2, resume2;
  logic [2:0]  imm_format2, id_ex_imm_format2;
  logic        stall2, halted2, id_ex_valid2;
  logic [4:0]  id_ex_rs1_2, id_ex_rs2_2, id_ex_rd2;
  logic        rw2, mr2, mw2, br2, jp2, tr2;
  logic [2:0]  stall_count2;

  decode_hazard_controller #(.COUNT_W(32), .RESET_HALTED(1'b0)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .flush_in(flush_in), .resume_in(resume_in), .imm_format(imm_format),
    .stall_out(stall_out), .halted(halted), .id_ex_valid(id_ex_valid),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_imm_format(id_ex_imm_format), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump), .id_ex_trap(id_ex_trap),
    .stall_count(stall_count)
  );

  decode_hazard_controller #(.COUNT_W(3), .RESET_HALTED(1'b1)) dut_sat (
    .clk(clk), .reset(reset2), .if_id_valid(1'b0), .if_id_instr(32'h0),
    .flush_in(1'b0), .resume_in(resume2), .imm_format(imm_format2),
    .stall_out(stall2), .halted(halted2), .id_ex_valid(id_ex_valid2),
    .id_ex_rs1(id_ex_rs1_2), .id_ex_rs2(id_ex_rs2_2), .id_ex_rd(id_ex_rd2),
    .id_ex_imm_format(id_ex_imm_format2), .id_ex_reg_write(rw2),
    .id_ex_mem_read(mr2), .id_ex_mem_write(mw2), .id_ex_branch(br2),
    .id_ex_jump(jp2), .id_ex_trap(tr2), .stall_count(stall_count2)
  );

  typedef struct {
    logic        rst, valid, flush, resume;
    logic [31:0] instr;
    logic [2:0]  e_fmt;
    logic        e_stall, e_halted;
    logic        e_v;
    logic [4:0]  e_rd;
    logic [2:0]  e_ifmt;
    logic [5:0]  e_ctrl;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] instr;
    logic        v;
    logic [4:0]  rd;
    logic [2:0]  ifmt;
    logic [5:0]  ctrl;
    logic [31:0] cnt;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(logic rst, logic valid, logic flush, logic resume,
                              logic [31:0] instr, logic [2:0] fmt, logic stall,
                              logic hlt, logic v, logic [4:0] rd, logic [2:0] ifmt,
                              logic [5:0] ctrl, logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.valid = valid; r.flush = flush; r.resume = resume;
    r.instr = instr; r.e_fmt = fmt; r.e_stall = stall; r.e_halted = hlt;
    r.e_v = v; r.e_rd = rd; r.e_ifmt = ifmt; r.e_ctrl = ctrl; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    post_t p;
    @(negedge clk);
    reset       = v.rst;
    if_id_valid = v.valid;
    if_id_instr = v.instr;
    flush_in    = v.flush;
    resume_in   = v.resume;
    #1;
    check($sformatf("v%0d imm_format", idx), 32'(imm_format), 32'(v.e_fmt));
    check($sformatf("v%0d stall_out", idx), 32'(stall_out), 32'(v.e_stall));
    check($sformatf("v%0d halted", idx), 32'(halted), 32'(v.e_halted));
    p.idx = idx; p.instr = v.instr; p.v = v.e_v; p.rd = v.e_rd;
    p.ifmt = v.e_ifmt; p.ctrl = v.e_ctrl; p.cnt = v.e_cnt;
    sb.push_back(p);
  endtask

  task automatic checkOutput(post_t p);
    logic [4:0] exp_rs1, exp_rs2;
    exp_rs1 = p.v ? p.instr[19:15] : 5'd0;
    exp_rs2 = p.v ? p.instr[24:20] : 5'd0;
    check($sformatf("v%0d id_ex_valid", p.idx), 32'(id_ex_valid), 32'(p.v));
    check($sformatf("v%0d id_ex_rd", p.idx), 32'(id_ex_rd), 32'(p.rd));
    check($sformatf("v%0d id_ex_rs1", p.idx), 32'(id_ex_rs1), 32'(exp_rs1));
    check($sformatf("v%0d id_ex_rs2", p.idx), 32'(id_ex_rs2), 32'(exp_rs2));
    check($sformatf("v%0d id_ex_imm_format", p.idx), 32'(id_ex_imm_format), 32'(p.ifmt));
    check($sformatf("v%0d id_ex_ctrl", p.idx),
          32'({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_branch, id_ex_jump, id_ex_trap}), 32'(p.ctrl));
    check($sformatf("v%0d stall_count", p.idx), stall_count, p.cnt);
  endtask

  // Scoreboard drain: each entry describes the ID/EX state after the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    //            rst v  fl rs instr  fmt stl hlt  v  rd  ifmt ctrl       cnt
    vecs.push_back(mk(0, 1, 0, 0, LW,    0, 0, 0,  1, 5,  0, 6'b110000, 1'b0 ? 1 : 0));
    vecs.push_back(mk(0, 1, 0, 0, ADD,   7, 1, 0,  0, 0,  0, 6'b000000, 1));
    vecs.push_back(mk(0, 1, 0, 0, ADD,   7, 0, 0,  1, 6,  7, 6'b100000, 1));
    vecs.push_back(mk(0, 1, 0, 0, LW0,   0, 0, 0,  1, 0,  0, 6'b010000, 1));
    vecs.push_back(mk(0, 1, 0, 0, ADD0,  7, 0, 0,  1, 6,  7, 6'b100000, 1));
    vecs.push_back(mk(0, 1, 0, 0, SW,    1, 0, 0,  1, 0,  1, 6'b001000, 1));
    vecs.push_back(mk(0, 1, 0, 0, BEQ,   2, 0, 0,  1, 8,  2, 6'b000100, 1));
    vecs.push_back(mk(0, 1, 0, 0, LUI,   3, 0, 0,  1, 5,  3, 6'b100000, 1));
    vecs.push_back(mk(0, 1, 0, 0, JAL,   4, 0, 0,  1, 1,  4, 6'b100010, 1));
    vecs.push_back(mk(0, 0, 0, 0, ADD,   7, 0, 0,  0, 0,  0, 6'b000000, 1));
    vecs.push_back(mk(0, 1, 0, 0, LW,    0, 0, 0,  1, 5,  0, 6'b110000, 1));
    vecs.push_back(mk(0, 1, 1, 0, ADD,   7, 0, 0,  0, 0,  0, 6'b000000, 1));
    vecs.push_back(mk(0, 1, 0, 0, ADD,   7, 0, 0,  1, 6,  7, 6'b100000, 1));
    vecs.push_back(mk(1, 0, 0, 0, ADD,   7, 0, 0,  0, 0,  0, 6'b000000, 0));
    vecs.push_back(mk(0, 1, 0, 0, ECALL, 0, 0, 0,  1, 0,  0, 6'b000001, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 1, 0, 0, ADD, 7, 1, 1,  0, 0,  0, 6'b000000, 32'(i)));
    vecs.push_back(mk(0, 1, 0, 1, ADD,   7, 1, 1,  0, 0,  0, 6'b000000, 6));
    vecs.push_back(mk(0, 1, 0, 0, ADD,   7, 0, 0,  1, 6,  7, 6'b100000, 6));
    vecs.push_back(mk(0, 1, 0, 0, ILL,   7, 0, 0,  1, 0,  7, 6'b000001, 6));
    vecs.push_back(mk(0, 0, 0, 0, ILL,   7, 1, 1,  0, 0,  0, 6'b000000, 7));
    vecs.push_back(mk(1, 0, 0, 0, ILL,   7, 1, 1,  0, 0,  0, 6'b000000, 0));
    vecs.push_back(mk(0, 0, 0, 0, ADD,   7, 0, 0,  0, 0,  0, 6'b000000, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADD,   7, 0, 0,  0, 0,  0, 6'b000000, 0));
    vecs.push_back(mk(0, 1, 0, 0, LW,    0, 0, 0,  1, 5,  0, 6'b110000, 0));

    reset = 1'b1; reset2 = 1'b1; resume2 = 1'b0;
    if_id_valid = 1'b0; if_id_instr = 32'h0; flush_in = 1'b0; resume_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset halted", 32'(halted), 32'd0);
    check("reset stall_out", 32'(stall_out), 32'd0);
    check("reset id_ex_valid", 32'(id_ex_valid), 32'd0);
    check("reset id_ex_ctrl", 32'({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                                   id_ex_branch, id_ex_jump, id_ex_trap}), 32'd0);
    check("reset stall_count", stall_count, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    @(negedge clk);
    if_id_valid = 1'b0; resume_in = 1'b0; flush_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // Debug-boot instance: leaves reset halted and its 3-bit counter saturates.
    @(negedge clk);
    check("boot halted", 32'(halted2), 32'd1);
    check("boot stall_out", 32'(stall2), 32'd1);
    check("boot stall_count", 32'(stall_count2), 32'd0);
    reset2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat count 3", 32'(stall_count2), 32'd3);
    repeat (7) @(posedge clk);
    #1;
    check("sat count hold", 32'(stall_count2), 32'd7);
    check("sat halted", 32'(halted2), 32'd1);
    @(negedge clk);
    resume2 = 1'b1;
    @(posedge clk);
    #1;
    resume2 = 1'b0;
    check("sat resume halted", 32'(halted2), 32'd0);
    check("sat resume stall_out", 32'(stall2), 32'd0);
    check("sat resume count", 32'(stall_count2), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
